tlc_nway: RTL and testbench

Parametrised N-direction traffic light controller: successor to the two-road controller. It adds a configurable number of approaches, timed green/yellow/all-red phases with minimum and maximum green, round-robin service of waiting approaches, and an emergency all-red override. It sits between the per-approach vehicle sensors and the lamp drivers. It is a Moore machine: lamp outputs depend only on registered state, with no input-to-output path.

---
 rtl/tlc_pkg.sv | 28 ++
 rtl/tlc_rr_arb.sv | 46 ++++
 rtl/tlc_nway.sv | 137 +++++++++++++
 tb/tb_tlc_nway.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared lamp/phase encodings and timer sizing for tlc_nway.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b11;

    localparam logic [1:0] PH_GREEN   = 2'b11;
    localparam logic [1:0] PH_YELLOW  = 2'b01;
    localparam logic [1:0] PH_ALL_RED = 2'b00;

    // Timer must hold the largest of the three phase lengths.
    function automatic int cnt_w(input int max_green, input int yellow_time,
                                 input int all_red_time);
        int m;
        m = max_green;
        if (yellow_time > m)  m = yellow_time;
        if (all_red_time > m) m = all_red_time;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tlc_rr_arb
// Description : Combinational round-robin picker; cur has lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_rr_arb
    import tlc_pkg::*;
#(
    parameter int NUM_DIR = 4
) (
    input  logic [NUM_DIR-1:0]         req,
    input  logic [$clog2(NUM_DIR)-1:0] cur,
    output logic [$clog2(NUM_DIR)-1:0] nxt,
    output logic                       any_other
);

    localparam int c_IDX_W = $clog2(NUM_DIR);

    int w_dist;
    int w_best;

    // Distance cur+1 .. cur+NUM_DIR; cur itself maps to NUM_DIR (last).
    always_comb begin
        nxt       = cur;
        any_other = 1'b0;
        w_dist    = 0;
        w_best    = NUM_DIR + 1;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (req[i]) begin
                w_dist = (i - int'(cur) + NUM_DIR) % NUM_DIR;
                if (w_dist == 0) begin
                    w_dist = NUM_DIR;
                end else begin
                    any_other = 1'b1;
                end
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    nxt    = c_IDX_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlc_nway.sv
`default_nettype none
// ============================================================================
// Module      : tlc_nway
// Description : N-approach Moore traffic light controller with min/max green,
//               round-robin service and emergency all-red hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_nway
    import tlc_pkg::*;
#(
    parameter int NUM_DIR      = 4,
    parameter int MIN_GREEN    = 8,
    parameter int MAX_GREEN    = 32,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_DIR-1:0]           T,
    input  logic                         EMG,
    output logic [2*NUM_DIR-1:0]         L,
    output logic [$clog2(NUM_DIR)-1:0]   GRANT,
    output logic [1:0]                   PHASE
);

    localparam int c_IDX_W = $clog2(NUM_DIR);
    localparam int c_CNT_W = cnt_w(MAX_GREEN, YELLOW_TIME, ALL_RED_TIME);

    localparam logic [c_CNT_W-1:0] c_MIN_M1 = c_CNT_W'(MIN_GREEN - 1);
    localparam logic [c_CNT_W-1:0] c_MAX_M1 = c_CNT_W'(MAX_GREEN - 1);
    localparam logic [c_CNT_W-1:0] c_YEL_M1 = c_CNT_W'(YELLOW_TIME - 1);
    localparam logic [c_CNT_W-1:0] c_AR_M1  = c_CNT_W'(ALL_RED_TIME - 1);

    localparam logic [1:0] c_S_GREEN   = PH_GREEN;
    localparam logic [1:0] c_S_YELLOW  = PH_YELLOW;
    localparam logic [1:0] c_S_ALL_RED = PH_ALL_RED;

    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_chk_num_dir
        $error("tlc_nway: NUM_DIR must be in 2..8");
    end
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN) begin : g_chk_green
        $error("tlc_nway: need 1 <= MIN_GREEN <= MAX_GREEN");
    end
    if (YELLOW_TIME < 1 || ALL_RED_TIME < 1) begin : g_chk_clear
        $error("tlc_nway: YELLOW_TIME and ALL_RED_TIME must be >= 1");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_cur;
    logic [c_IDX_W-1:0] w_cur_nxt;
    logic [c_CNT_W-1:0] r_timer;
    logic [c_CNT_W-1:0] w_timer_nxt;
    logic [c_IDX_W-1:0] w_arb_nxt;
    logic               w_other_req;

    tlc_rr_arb #(
        .NUM_DIR (NUM_DIR)
    ) u_arb (
        .req       (T),
        .cur       (r_cur),
        .nxt       (w_arb_nxt),
        .any_other (w_other_req)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_S_GREEN;
            r_cur   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        case (r_state)
            c_S_GREEN: begin
                if (EMG ||
                    (r_timer >= c_MIN_M1 && !T[r_cur] && w_other_req) ||
                    (r_timer == c_MAX_M1 && w_other_req)) begin
                    w_state_nxt = c_S_YELLOW;
                end
            end
            c_S_YELLOW: begin
                if (r_timer == c_YEL_M1) begin
                    w_state_nxt = c_S_ALL_RED;
                end
            end
            c_S_ALL_RED: begin
                if (r_timer >= c_AR_M1 && !EMG) begin
                    w_state_nxt = c_S_GREEN;
                    w_cur_nxt   = w_arb_nxt;
                end
            end
            default: begin
                w_state_nxt = c_S_GREEN;
            end
        endcase
    end

    // Green saturates so max-green stays armed; all-red saturates under EMG.
    always_comb begin
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (r_state == c_S_GREEN && r_timer == c_MAX_M1) begin
            w_timer_nxt = r_timer;
        end else if (r_state == c_S_ALL_RED && r_timer >= c_AR_M1) begin
            w_timer_nxt = r_timer;
        end else begin
            w_timer_nxt = r_timer + 1'b1;
        end
    end

    always_comb begin
        L = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            L[2*i +: 2] = RED;
            if (i == int'(r_cur)) begin
                if (r_state == c_S_GREEN) begin
                    L[2*i +: 2] = GREEN;
                end else if (r_state == c_S_YELLOW) begin
                    L[2*i +: 2] = YELLOW;
                end
            end
        end
    end

    assign GRANT = r_cur;
    assign PHASE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tlc_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_nway
// Description : Scoreboard bench for tlc_nway with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_nway;

    localparam int c_N    = 4;
    localparam int c_MIN  = 8;
    localparam int c_MAX  = 32;
    localparam int c_YEL  = 4;
    localparam int c_AR   = 2;

    logic           CLK;
    logic           RST;
    logic [c_N-1:0] T;
    logic           EMG;
    logic [2*c_N-1:0] L;
    logic [1:0]     GRANT;
    logic [1:0]     PHASE;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0=green 1=yellow 2=all-red, elapsed cycles in phase.
    int m_ph;
    int m_cur;
    int m_el;

    logic [11:0] sb_q[$];

    tlc_nway #(
        .NUM_DIR      (c_N),
        .MIN_GREEN    (c_MIN),
        .MAX_GREEN    (c_MAX),
        .YELLOW_TIME  (c_YEL),
        .ALL_RED_TIME (c_AR)
    ) u_dut (
        .CLK   (CLK),
        .RST   (RST),
        .T     (T),
        .EMG   (EMG),
        .L     (L),
        .GRANT (GRANT),
        .PHASE (PHASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [7:0] lamps;
        logic [1:0] ph;
        lamps = 8'h00;
        if (m_ph == 0) begin
            lamps[2*m_cur]   = 1'b1;
            lamps[2*m_cur+1] = 1'b1;
            ph = 2'b11;
        end else if (m_ph == 1) begin
            lamps[2*m_cur] = 1'b1;
            ph = 2'b01;
        end else begin
            ph = 2'b00;
        end
        return {lamps, 2'(m_cur), ph};
    endfunction

    function automatic void model_reset();
        m_ph  = 0;
        m_cur = 0;
        m_el  = 0;
    endfunction

    function automatic void model_step(input logic [c_N-1:0] t, input logic e);
        bit other;
        bit leave;
        int pick;
        other = 0;
        for (int j = 0; j < c_N; j++) if (j != m_cur && t[j]) other = 1;
        leave = 0;
        case (m_ph)
            0: leave = e || (m_el >= c_MIN-1 && !t[m_cur] && other) ||
                       (m_el >= c_MAX-1 && other);
            1: leave = (m_el == c_YEL-1);
            default: leave = (m_el >= c_AR-1) && !e;
        endcase
        if (leave) begin
            if (m_ph == 2) begin
                pick = m_cur;
                for (int d = c_N; d >= 1; d--) if (t[(m_cur + d) % c_N]) pick = (m_cur + d) % c_N;
                m_cur = pick;
            end
            m_ph = (m_ph + 1) % 3;
            m_el = 0;
        end else begin
            m_el++;
        end
    endfunction

    // Drive one cycle of inputs, predict, and compare after the edge.
    task automatic tick(input logic [c_N-1:0] t, input logic e);
        logic [11:0] exp_v;
        T   = t;
        EMG = e;
        model_step(t, e);
        sb_q.push_back(model_out());
        @(posedge CLK);
        #1;
        exp_v = sb_q.pop_front();
        check("cycle", {20'h0, L, GRANT, PHASE}, {20'h0, exp_v});
        @(negedge CLK);
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b0;
        #1;
        check("rst_L", {24'h0, L}, 32'h03);
        check("rst_grant", {30'h0, GRANT}, 32'h0);
        check("rst_phase", {30'h0, PHASE}, 32'h3);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        bit reached;
        logic [c_N-1:0] rt;
        logic           re;
        RST = 1'b0;
        T   = '0;
        EMG = 1'b0;
        model_reset();
        @(negedge CLK);
        check("rst_L", {24'h0, L}, 32'h03);
        check("rst_phase", {30'h0, PHASE}, 32'h3);
        RST = 1'b1;

        // Idle: approach 0 holds green.
        repeat (100) tick(4'b0000, 1'b0);
        check("idle_L", {24'h0, L}, 32'h03);

        // Single waiting approach after MIN_GREEN.
        do_reset();
        repeat (20) tick(4'b0100, 1'b0);
        check("t2_grant", {30'h0, GRANT}, 32'd2);
        check("t2_L", {24'h0, L}, 32'h30);

        // Current approach busy: max green, then rotation and back.
        do_reset();
        repeat (40) tick(4'b0011, 1'b0);
        check("t3_grant1", {30'h0, GRANT}, 32'd1);
        repeat (40) tick(4'b0011, 1'b0);
        check("t3_grant0", {30'h0, GRANT}, 32'd0);

        // Round-robin picks 2 after 1, not 0.
        do_reset();
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick(4'b0010, 1'b0);
            reached = (m_cur == 1 && m_ph == 0);
        end
        check("t4_steer", {31'h0, reached}, 32'd1);
        repeat (20) tick(4'b0101, 1'b0);
        check("t4_grant", {30'h0, GRANT}, 32'd2);

        // Emergency during green, held 10 cycles.
        do_reset();
        repeat (3) tick(4'b0000, 1'b0);
        repeat (10) tick(4'b0000, 1'b1);
        check("t5_hold", {30'h0, PHASE}, 32'd0);
        repeat (10) tick(4'b0000, 1'b0);
        check("t5_grant", {30'h0, GRANT}, 32'd0);
        check("t5_phase", {30'h0, PHASE}, 32'd3);

        // Asynchronous reset in the middle of approach 2's yellow.
        do_reset();
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick(4'b0100, 1'b0);
            reached = (m_cur == 2 && m_ph == 0);
        end
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick(4'b0001, 1'b0);
            reached = (m_cur == 2 && m_ph == 1);
        end
        check("t6_steer", {31'h0, reached}, 32'd1);
        tick(4'b0001, 1'b0);
        check("t6_yellow", {30'h0, PHASE}, 32'd1);
        do_reset();
        repeat (16) tick(4'b0010, 1'b0);

        // Random traffic with sporadic emergencies.
        rt = '0;
        re = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) rt = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) re = ~re;
            tick(rt, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
